// File: rtl/sata_oob_pkg.sv
// Shared types, default timing constants and the gap classifier for the SATA OOB detector.
// The defaults assume a 150 MHz receive clock (6.667 ns period).
package sata_oob_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StGap,
        StActive
    } oob_state_e;

    // ClsNone also stands for "invalid" when returned by classify_gap
    typedef enum logic [1:0] {
        ClsNone,
        ClsInit,
        ClsWake
    } run_class_e;

    localparam int unsigned CLK_PERIOD_PS    = 6667;
    localparam int unsigned DEF_CW           = 8;
    localparam int unsigned DEF_N_BURSTS     = 4;
    localparam int unsigned DEF_MIN_BURST    = 12;
    localparam int unsigned DEF_MAX_BURST    = 40;
    localparam int unsigned DEF_WAKE_GAP_MIN = 6;
    localparam int unsigned DEF_WAKE_GAP_MAX = 25;
    localparam int unsigned DEF_INIT_GAP_MIN = 27;
    localparam int unsigned DEF_INIT_GAP_MAX = 78;

    // Map a completed gap length onto the burst-train class it belongs to (bounds inclusive)
    function automatic run_class_e classify_gap(input int unsigned gap,
                                                input int unsigned wake_min,
                                                input int unsigned wake_max,
                                                input int unsigned init_min,
                                                input int unsigned init_max);
        if (gap >= wake_min && gap <= wake_max) begin
            return ClsWake;
        end
        if (gap >= init_min && gap <= init_max) begin
            return ClsInit;
        end
        return ClsNone;
    endfunction

endpackage

// File: rtl/sata_oob_deglitch.sv
// Input register stage for the electrical-idle indication.
// Build option SATA_OOB_GLITCH_FILTER_EN: when defined, the registered level only changes after
// the input has held its new value for two consecutive samples (adds one clock of latency).
module sata_oob_deglitch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_elec_idle,
    output logic o_idle_q
);

`ifdef SATA_OOB_GLITCH_FILTER_EN
    logic r_sample;
    logic r_idle;

    // Two-sample agreement filter; resets to the squelched level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sample <= 1'b1;
            r_idle   <= 1'b1;
        end else begin
            r_sample <= i_elec_idle;
            if (i_elec_idle == r_sample) begin
                r_idle <= i_elec_idle;
            end
        end
    end
`else
    logic r_idle;

    // Single register stage; every sample is honoured
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= i_elec_idle;
        end
    end
`endif

    assign o_idle_q = r_idle;

endmodule

// File: rtl/sata_oob_detect.sv
// Device-side OOB detector: measures burst/gap lengths on the registered squelch signal and
// pulses o_cominit / o_comwake after N_BURSTS qualified bursts of one class.
// Build option SATA_OOB_GLITCH_FILTER_EN selects the deglitching input stage (+1 clock latency).
module sata_oob_detect
    import sata_oob_pkg::*;
#(
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned N_BURSTS     = DEF_N_BURSTS,
    parameter int unsigned MIN_BURST    = DEF_MIN_BURST,
    parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
    parameter int unsigned WAKE_GAP_MIN = DEF_WAKE_GAP_MIN,
    parameter int unsigned WAKE_GAP_MAX = DEF_WAKE_GAP_MAX,
    parameter int unsigned INIT_GAP_MIN = DEF_INIT_GAP_MIN,
    parameter int unsigned INIT_GAP_MAX = DEF_INIT_GAP_MAX
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_elec_idle,
    output logic o_cominit,
    output logic o_comwake,
    output logic o_active,
    output logic o_squelch
);

    localparam int unsigned RW = $clog2(N_BURSTS + 1);

    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LEN_QUAL = CW'(MIN_BURST);
    localparam logic [CW-1:0] LEN_ACT  = CW'(MAX_BURST);
    localparam logic [CW-1:0] GAP_TMO  = CW'(INIT_GAP_MAX);
    localparam logic [RW-1:0] RUN_DONE = RW'(N_BURSTS);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);

    logic w_idle_q;

    oob_state_e r_state, w_state;
    run_class_e r_class, w_class;
    run_class_e w_gap_cls;
    logic [CW-1:0] r_len, w_len, w_len_inc;
    logic [CW-1:0] r_gap, w_gap, w_gap_inc;
    logic [RW-1:0] r_run, w_run;
    logic w_cominit, w_comwake;
    logic r_cominit, r_comwake, r_active, r_squelch;

    sata_oob_deglitch u_deglitch (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_elec_idle (i_elec_idle),
        .o_idle_q    (w_idle_q)
    );

    assign w_len_inc = (r_len == CNT_SAT) ? r_len : r_len + 1'b1;
    assign w_gap_inc = (r_gap == CNT_SAT) ? r_gap : r_gap + 1'b1;
    assign w_gap_cls = classify_gap(32'(r_gap), WAKE_GAP_MIN, WAKE_GAP_MAX,
                                    INIT_GAP_MIN, INIT_GAP_MAX);

    // Next-state, counter, run tracking and detect-pulse decode
    always_comb begin
        w_state   = r_state;
        w_len     = r_len;
        w_gap     = r_gap;
        w_run     = r_run;
        w_class   = r_class;
        w_cominit = 1'b0;
        w_comwake = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_idle_q) begin
                    w_state = StBurst;
                    w_len   = CNT_ONE;
                end
            end
            StBurst: begin
                if (!w_idle_q) begin
                    w_len = w_len_inc;
                    // Bursts this long are real data, not OOB signalling
                    if (w_len_inc >= LEN_ACT) begin
                        w_state = StActive;
                        w_run   = '0;
                        w_class = ClsNone;
                    end
                end else begin
                    w_state = StGap;
                    w_gap   = CNT_ONE;
                    if (r_len < LEN_QUAL) begin
                        w_run   = '0;
                        w_class = ClsNone;
                    end else begin
                        if (r_run != RUN_DONE) begin
                            w_run = r_run + 1'b1;
                        end
                        if (w_run == RUN_DONE && r_class != ClsNone) begin
                            w_cominit = (r_class == ClsInit);
                            w_comwake = (r_class == ClsWake);
                            w_run     = '0;
                            w_class   = ClsNone;
                        end
                    end
                end
            end
            StGap: begin
                if (w_idle_q) begin
                    w_gap = w_gap_inc;
                    if (w_gap_inc > GAP_TMO) begin
                        w_state = StIdle;
                        w_run   = '0;
                        w_class = ClsNone;
                    end
                end else begin
                    w_state = StBurst;
                    w_len   = CNT_ONE;
                    if (r_run != '0) begin
                        if (w_gap_cls == ClsNone) begin
                            w_run   = '0;
                            w_class = ClsNone;
                        end else if (r_class == ClsNone || r_class == w_gap_cls) begin
                            w_class = w_gap_cls;
                        end else begin
                            // The burst before this gap opens a run of the new class
                            w_run   = RUN_ONE;
                            w_class = w_gap_cls;
                        end
                    end
                end
            end
            StActive: begin
                if (w_idle_q) begin
                    w_state = StGap;
                    w_gap   = CNT_ONE;
                    w_run   = '0;
                    w_class = ClsNone;
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_len     <= '0;
            r_gap     <= '0;
            r_run     <= '0;
            r_class   <= ClsNone;
            r_cominit <= 1'b0;
            r_comwake <= 1'b0;
            r_active  <= 1'b0;
            r_squelch <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_len     <= w_len;
            r_gap     <= w_gap;
            r_run     <= w_run;
            r_class   <= w_class;
            r_cominit <= w_cominit;
            r_comwake <= w_comwake;
            r_active  <= (w_state == StActive);
            r_squelch <= (w_state == StIdle);
        end
    end

    assign o_cominit = r_cominit;
    assign o_comwake = r_comwake;
    assign o_active  = r_active;
    assign o_squelch = r_squelch;

endmodule
